rr_mux: RTL
===========

# rr_mux

Parametrised, registered N-to-1 multiplexer with per-channel valid/ready handshakes, selectable between fixed-select and round-robin arbitration. Successor to the combinational 4:1 single-bit mux. Sits between several producer channels and one consumer, delivering one W-bit word per accepted transfer with a channel tag.

## Interface
- `W`, default 8: data width per channel.
- `N`, default 4: channel count, N ≥ 2.
- `SW`: localparam, $clog2(N); width of select and tag.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_data`  in  N*W  channel i occupies bits [i*W +: W].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready, combinational, at most one bit set.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  SW  channel used in fixed mode.
- `out_data`  out  W  registered output word.
- `out_ch`  out  SW  registered index of the source channel.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.

## Operation
- One output register (data, ch, valid) and one rotation pointer `ptr` [SW-1:0].
- `load_en = !out_valid || out_ready`.
- Grant selection, combinational each cycle:
  - Fixed mode: grant `sel` if `sel < N` and `in_valid[sel]`, else no grant. Other channels are never granted.
  - RR mode: first i with `in_valid[i]`, searching `ptr, ptr+1, …, N-1, 0, …, ptr-1` (wrap modulo N). No grant if none is valid.
- `in_ready[g] = load_en` for granted g; all other bits 0. A transfer on channel g is `in_valid[g] && in_ready[g]`.
- On a transfer: `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`. In RR mode `ptr <= (g == N-1) ? 0 : g+1`. In fixed mode `ptr` holds.
- If `out_valid && out_ready` and no transfer: `out_valid <= 0`. `out_data` and `out_ch` hold.
- If `out_valid && !out_ready`: all output registers hold. `in_ready` is all 0.
- `mode` and `sel` are sampled every cycle. A change affects the next grant only and never the word already registered.
- Changing `mode` does not reset `ptr`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0`. `in_ready` is 0 during `rst`.
- Latency: a word accepted at edge k appears on `out_data`/`out_valid` after edge k.
- Throughput: one word per cycle when `out_ready` is held high. Back-to-back transfers have no bubble.
- Simultaneous drain and load: a new word replaces the drained one in the same cycle, and `out_valid` stays 1.
- `rst` asserted mid-transfer: `rst` takes priority. The in-flight word is dropped, registers go to reset values on that edge, and no transfer is counted.
- Producers must hold `in_data`/`in_valid` stable until the handshake. The block does not check this.
- No combinational path from `out_ready` to `out_data`. There is a combinational path from `out_ready`, `in_valid`, `mode` and `sel` to `in_ready`.

## Structure
- Shared package `rr_mux_pkg` holds `MODE_FIXED = 1'b0` and `MODE_RR = 1'b1`.
- One sub-module, `rr_arbiter`: inputs `req[N]`, `ptr`. Outputs `gnt_valid` and `gnt_idx[SW]`. It is purely combinational rotate-priority logic.
- The top level holds the pointer, the output register and the handshake logic.

## Test plan
- Reset: assert `rst` 2 cycles with all `in_valid=1` -> `out_valid=0`, `in_ready=0`, `out_ch=0`. On the first cycle after release in RR mode, channel 0 is granted.
- Fixed mode, `sel=2`, `in_valid=4'b1111`, `in_data` ch2 = 0xA5, `out_ready=1` -> only `in_ready[2]` is high. `out_data=0xA5`, `out_ch=2` one cycle later, every cycle.
- RR fairness: `mode=1`, all channels valid, `out_ready=1` for 8 cycles -> `out_ch` sequence is 0,1,2,3,0,1,2,3.
- RR skip and wrap: `in_valid=4'b1001`, `ptr=1` -> grant ch3, then ch0, then ch3.
- Backpressure: `out_valid=1`, `out_ready=0` for 3 cycles -> `in_ready=0`, `out_data` and `out_ch` stable. Then raise `out_ready` -> drain and reload in the same cycle, with `out_valid` staying 1.
- Fixed mode `sel=3` with `N=3` (out of range) -> no grant, `out_valid` falls after the drain. Mid-stream `rst` -> `out_valid=0` the next cycle.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared constants for the rr_mux block: arbitration mode encodings.
package rr_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  int idx;

  // Scan farthest-first so the nearest request to ptr is the last one written.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// Registered N-to-1 handshake mux with fixed-select or round-robin arbitration.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_ch,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          arb_valid;
  logic [SW-1:0] arb_idx;
  logic          fix_valid;
  logic          gnt_valid;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;
  logic          load_en;
  logic          xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // An out-of-range sel matches no channel, so fixed mode simply grants nothing.
  always_comb begin
    fix_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) fix_valid = in_valid[i];
    end
  end

  assign gnt_valid = (mode == MODE_RR) ? arb_valid : fix_valid;
  assign gnt_idx   = (mode == MODE_RR) ? arb_idx   : sel;
  assign load_en   = !out_valid_q || out_ready;
  assign xfer      = gnt_valid && load_en && !rst;

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) begin
        gnt_data    = in_data[i*W +: W];
        in_ready[i] = xfer;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
